pump_sequencer: RTL and testbench

//  Next-generation tank pump controller: debounced level sensors with a parametrised code range,

---
 rtl/pump_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_pump_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pump_sequencer.sv
// Tank pump controller: debounced level sensors, start/stop thresholds, anti-short-cycle
// timers, dry-run timeout and a sticky FAULT state driving pump, solenoid and LEDs.

module pump_seq_debounce #(
    parameter int LVL_W             = 3,
    parameter int LVL_MAX           = 4,
    parameter int INVERT_LEVEL_CODE = 0,
    parameter int DEB_CYC           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LVL_W-1:0] raw,
    output logic [LVL_W-1:0] lvl
);

    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [LVL_W-1:0] FULL_CODE = LVL_W'(LVL_MAX);

    logic [LVL_W-1:0] corr;
    logic [LVL_W-1:0] cand_d, cand_q;
    logic [LVL_W-1:0] lvl_d, lvl_q;
    logic [DEB_W-1:0] cnt_d, cnt_q;

    // cnt counts identical samples minus one; the filtered value moves on the DEB_CYC-th one.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        corr   = (INVERT_LEVEL_CODE != 0) ? (FULL_CODE - raw) : raw;
        cand_d = cand_q;
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        if (corr != cand_q) begin
            cand_d = corr;
            cnt_d  = '0;
        end else if (cnt_q != DEB_LAST) begin
            cnt_d = cnt_q + DEB_W'(1);
        end
        if (cnt_d == DEB_LAST) begin
            lvl_d = cand_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is written only with non-blocking assignments.
        if (rst) begin
            cand_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
        end
    end

    assign lvl = lvl_q;

endmodule

module pump_sequencer #(
    parameter int LVL_W             = 3,
    parameter int LVL_MAX           = 4,
    parameter int INVERT_LEVEL_CODE = 0,
    parameter int START_SUP_MAX     = 1,
    parameter int START_INF_MIN     = 3,
    parameter int STOP_SUP_MIN      = 3,
    parameter int STOP_INF_MAX      = 1,
    parameter int DEB_CYC           = 4,
    parameter int MIN_ON_CYC        = 16,
    parameter int MIN_OFF_CYC       = 16,
    parameter int DRY_TO_CYC        = 1024,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fault_clr,
    input  logic [LVL_W-1:0] lvl_inf_raw,
    input  logic [LVL_W-1:0] lvl_sup_raw,
    output logic [LVL_W-1:0] lvl_inf,
    output logic [LVL_W-1:0] lvl_sup,
    output logic             pump_on,
    output logic             solenoid_open,
    output logic             led_green,
    output logic             led_red,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [1:0]       state_o
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PUMP  = 2'b01;
    localparam logic [1:0] ST_FAULT = 2'b10;

    localparam logic [1:0] FC_NONE   = 2'b00;
    localparam logic [1:0] FC_SENSOR = 2'b01;
    localparam logic [1:0] FC_DRY    = 2'b10;

    localparam logic [LVL_W-1:0] FULL_CODE = LVL_W'(LVL_MAX);
    localparam logic [LVL_W-1:0] START_SUP = LVL_W'(START_SUP_MAX);
    localparam logic [LVL_W-1:0] START_INF = LVL_W'(START_INF_MIN);
    localparam logic [LVL_W-1:0] STOP_SUP  = LVL_W'(STOP_SUP_MIN);
    localparam logic [LVL_W-1:0] STOP_INF  = LVL_W'(STOP_INF_MAX);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] MIN_ON   = CNT_W'(MIN_ON_CYC);
    localparam logic [CNT_W-1:0] MIN_OFF  = CNT_W'(MIN_OFF_CYC);
    localparam logic [CNT_W-1:0] DRY_LAST = CNT_W'(DRY_TO_CYC - 1);

    logic [LVL_W-1:0] inf_f, sup_f;
    logic [LVL_W-1:0] sup_prev_q;
    logic [1:0]       state_d, state_q;
    logic [1:0]       fault_code_d, fault_code_q;
    logic [CNT_W-1:0] off_cnt_d, off_cnt_q;
    logic [CNT_W-1:0] on_cnt_d, on_cnt_q;
    logic [CNT_W-1:0] dry_cnt_d, dry_cnt_q;

    logic sensor_bad;
    logic start_cond;
    logic stop_cond;
    logic sup_rise;

    pump_seq_debounce #(
        .LVL_W            (LVL_W),
        .LVL_MAX          (LVL_MAX),
        .INVERT_LEVEL_CODE(INVERT_LEVEL_CODE),
        .DEB_CYC          (DEB_CYC)
    ) u_deb_inf (
        .clk(clk),
        .rst(rst),
        .raw(lvl_inf_raw),
        .lvl(inf_f)
    );

    pump_seq_debounce #(
        .LVL_W            (LVL_W),
        .LVL_MAX          (LVL_MAX),
        .INVERT_LEVEL_CODE(INVERT_LEVEL_CODE),
        .DEB_CYC          (DEB_CYC)
    ) u_deb_sup (
        .clk(clk),
        .rst(rst),
        .raw(lvl_sup_raw),
        .lvl(sup_f)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        sensor_bad = (inf_f > FULL_CODE) || (sup_f > FULL_CODE);
        start_cond = (sup_f <= START_SUP) && (inf_f >= START_INF);
        stop_cond  = (sup_f >= STOP_SUP) || (inf_f <= STOP_INF);
        sup_rise   = sup_f > sup_prev_q;
    end

    // Transition priority: sensor fault, dry-run, enable drop, normal stop / start.
    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        case (state_q)
            ST_IDLE: begin
                if (sensor_bad) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_SENSOR;
                end else if (en && start_cond && (off_cnt_q >= MIN_OFF)) begin
                    state_d = ST_PUMP;
                end
            end
            ST_PUMP: begin
                if (sensor_bad) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_SENSOR;
                end else if (dry_cnt_q == DRY_LAST) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_DRY;
                end else if (!en) begin
                    state_d = ST_IDLE;
                end else if (stop_cond && (on_cnt_q >= MIN_ON)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !sensor_bad) begin
                    state_d      = ST_IDLE;
                    fault_code_d = FC_NONE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                fault_code_d = FC_NONE;
            end
        endcase
    end

    // Each counter restarts from zero on the edge that enters its state.
    always_comb begin
        off_cnt_d = off_cnt_q;
        on_cnt_d  = on_cnt_q;
        dry_cnt_d = dry_cnt_q;

        if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
            off_cnt_d = '0;
        end else if (state_q == ST_IDLE) begin
            off_cnt_d = sat_inc(off_cnt_q);
        end

        if ((state_d == ST_PUMP) && (state_q != ST_PUMP)) begin
            on_cnt_d  = '0;
            dry_cnt_d = '0;
        end else if (state_q == ST_PUMP) begin
            on_cnt_d  = sat_inc(on_cnt_q);
            dry_cnt_d = sup_rise ? '0 : sat_inc(dry_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fault_code_q <= FC_NONE;
            off_cnt_q    <= '0;
            on_cnt_q     <= '0;
            dry_cnt_q    <= '0;
            sup_prev_q   <= '0;
        end else begin
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
            off_cnt_q    <= off_cnt_d;
            on_cnt_q     <= on_cnt_d;
            dry_cnt_q    <= dry_cnt_d;
            sup_prev_q   <= sup_f;
        end
    end

    assign lvl_inf       = inf_f;
    assign lvl_sup       = sup_f;
    assign pump_on       = (state_q == ST_PUMP);
    assign solenoid_open = !((state_q == ST_FAULT) || (inf_f == FULL_CODE));
    assign led_green     = pump_on;
    assign led_red       = solenoid_open;
    assign fault         = (state_q == ST_FAULT);
    assign fault_code    = fault_code_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pump_sequencer.sv
// Directed bench for pump_sequencer: hand-written startup/min-on/glitch/dry-run/reset
// sequences plus a table of fault, solenoid and enable vectors.

module tb_pump_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       fault_clr;
    logic [2:0] lvl_inf_raw;
    logic [2:0] lvl_sup_raw;
    logic [2:0] lvl_inf;
    logic [2:0] lvl_sup;
    logic       pump_on;
    logic       solenoid_open;
    logic       led_green;
    logic       led_red;
    logic       fault;
    logic [1:0] fault_code;
    logic [1:0] state_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] inf;
        logic [2:0] sup;
        logic       en;
        logic       clr;
        int         hold;
        logic [1:0] st;
        logic       pump;
        logic       sol;
        logic [1:0] code;
        logic [2:0] li;
        logic [2:0] ls;
    } vec_t;

    vec_t tbl [13];

    pump_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fault_clr    (fault_clr),
        .lvl_inf_raw  (lvl_inf_raw),
        .lvl_sup_raw  (lvl_sup_raw),
        .lvl_inf      (lvl_inf),
        .lvl_sup      (lvl_sup),
        .pump_on      (pump_on),
        .solenoid_open(solenoid_open),
        .led_green    (led_green),
        .led_red      (led_red),
        .fault        (fault),
        .fault_code   (fault_code),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] outs();
        return {state_o, pump_on, solenoid_open, led_green, led_red, fault, fault_code,
                lvl_inf, lvl_sup};
    endfunction

    // Expected packed outputs; LEDs mirror pump/solenoid, fault follows the FAULT state.
    function automatic logic [14:0] expv(input logic [1:0] st, input logic pump, input logic sol,
                                         input logic [1:0] code, input logic [2:0] li,
                                         input logic [2:0] ls);
        return {st, pump, sol, pump, sol, (st == 2'b10), code, li, ls};
    endfunction

    initial begin
        tbl[0]  = '{3'd3, 3'd1, 1'b1, 1'b1, 1,  2'd0, 1'b0, 1'b1, 2'd0, 3'd3, 3'd1};
        tbl[1]  = '{3'd4, 3'd1, 1'b1, 1'b0, 3,  2'd0, 1'b0, 1'b1, 2'd0, 3'd3, 3'd1};
        tbl[2]  = '{3'd4, 3'd1, 1'b1, 1'b0, 1,  2'd0, 1'b0, 1'b0, 2'd0, 3'd4, 3'd1};
        tbl[3]  = '{3'd6, 3'd1, 1'b1, 1'b0, 3,  2'd0, 1'b0, 1'b0, 2'd0, 3'd4, 3'd1};
        tbl[4]  = '{3'd6, 3'd1, 1'b1, 1'b0, 1,  2'd0, 1'b0, 1'b1, 2'd0, 3'd6, 3'd1};
        tbl[5]  = '{3'd6, 3'd1, 1'b1, 1'b0, 1,  2'd2, 1'b0, 1'b0, 2'd1, 3'd6, 3'd1};
        tbl[6]  = '{3'd6, 3'd1, 1'b1, 1'b1, 1,  2'd2, 1'b0, 1'b0, 2'd1, 3'd6, 3'd1};
        tbl[7]  = '{3'd3, 3'd1, 1'b1, 1'b0, 4,  2'd2, 1'b0, 1'b0, 2'd1, 3'd3, 3'd1};
        tbl[8]  = '{3'd3, 3'd1, 1'b1, 1'b1, 1,  2'd0, 1'b0, 1'b1, 2'd0, 3'd3, 3'd1};
        tbl[9]  = '{3'd3, 3'd1, 1'b0, 1'b0, 20, 2'd0, 1'b0, 1'b1, 2'd0, 3'd3, 3'd1};
        tbl[10] = '{3'd3, 3'd1, 1'b1, 1'b0, 1,  2'd1, 1'b1, 1'b1, 2'd0, 3'd3, 3'd1};
        tbl[11] = '{3'd3, 3'd1, 1'b0, 1'b0, 1,  2'd0, 1'b0, 1'b1, 2'd0, 3'd3, 3'd1};
        tbl[12] = '{3'd3, 3'd1, 1'b1, 1'b0, 1,  2'd0, 1'b0, 1'b1, 2'd0, 3'd3, 3'd1};

        rst = 1'b1; en = 1'b0; fault_clr = 1'b0;
        lvl_inf_raw = 3'd0; lvl_sup_raw = 3'd0;
        tick(2);
        check("reset", outs(), expv(2'd0, 1'b0, 1'b1, 2'd0, 3'd0, 3'd0));

        // Startup: no pump before the minimum off time has elapsed.
        rst = 1'b0; lvl_inf_raw = 3'd3; lvl_sup_raw = 3'd0; en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            check($sformatf("min_off_c%0d", k), {14'd0, pump_on}, 15'd0);
        end
        tick(1);
        check("start", outs(), expv(2'd1, 1'b1, 1'b1, 2'd0, 3'd3, 3'd0));

        // Stop request arrives at on_cnt=5; honoured only once on_cnt reaches 16.
        tick(1);
        lvl_sup_raw = 3'd3;
        tick(4);
        check("stop_early", outs(), expv(2'd1, 1'b1, 1'b1, 2'd0, 3'd3, 3'd3));
        tick(11);
        check("min_on_hold", outs(), expv(2'd1, 1'b1, 1'b1, 2'd0, 3'd3, 3'd3));
        tick(1);
        check("min_on_stop", outs(), expv(2'd0, 1'b0, 1'b1, 2'd0, 3'd3, 3'd3));

        // Restart with sup=1 after another minimum off time.
        lvl_sup_raw = 3'd1;
        tick(16);
        check("restart_wait", outs(), expv(2'd0, 1'b0, 1'b1, 2'd0, 3'd3, 3'd1));
        tick(1);
        check("restart", outs(), expv(2'd1, 1'b1, 1'b1, 2'd0, 3'd3, 3'd1));

        // Three-sample glitch must not reach the filtered level.
        lvl_sup_raw = 3'd3;
        tick(3);
        lvl_sup_raw = 3'd1;
        check("glitch_a", outs(), expv(2'd1, 1'b1, 1'b1, 2'd0, 3'd3, 3'd1));
        tick(4);
        check("glitch_b", outs(), expv(2'd1, 1'b1, 1'b1, 2'd0, 3'd3, 3'd1));

        // Dry run: 1024 pumping cycles since entry with sup never rising.
        tick(1016);
        check("dry_before", outs(), expv(2'd1, 1'b1, 1'b1, 2'd0, 3'd3, 3'd1));
        tick(1);
        check("dry_fault", outs(), expv(2'd2, 1'b0, 1'b0, 2'd2, 3'd3, 3'd1));

        for (int i = 0; i < 13; i++) begin
            lvl_inf_raw = tbl[i].inf;
            lvl_sup_raw = tbl[i].sup;
            en          = tbl[i].en;
            fault_clr   = tbl[i].clr;
            tick(tbl[i].hold);
            fault_clr   = 1'b0;
            check($sformatf("row%0d", i), outs(),
                  expv(tbl[i].st, tbl[i].pump, tbl[i].sol, tbl[i].code, tbl[i].li, tbl[i].ls));
        end

        // Asynchronous reset in the middle of a pumping run.
        tick(15);
        check("pre_rst_idle", {14'd0, pump_on}, 15'd0);
        tick(1);
        check("pre_rst_pump", outs(), expv(2'd1, 1'b1, 1'b1, 2'd0, 3'd3, 3'd1));
        #2 rst = 1'b1;
        #1;
        check("async_rst", outs(), expv(2'd0, 1'b0, 1'b1, 2'd0, 3'd0, 3'd0));
        tick(1);
        rst = 1'b0;
        tick(16);
        check("post_rst_wait", outs(), expv(2'd0, 1'b0, 1'b1, 2'd0, 3'd3, 3'd1));
        tick(1);
        check("post_rst_start", outs(), expv(2'd1, 1'b1, 1'b1, 2'd0, 3'd3, 3'd1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
